// File: rtl/i8bit_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i8bit_div_pkg
// Purpose  : Shared types and constants for the restoring divider:
//            FSM state encoding and default divisor width.
// Revision : 1.0  initial release
// ============================================================================
package i8bit_div_pkg;

    // Default divisor width; dividend and quotient are twice this width.
    localparam int N_DEFAULT = 8;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/i8bit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : i8bit_div_step
// Purpose  : One combinational restoring-division stage. Shifts the next
//            dividend bit into the partial remainder, compares against the
//            divisor and subtracts when the shifted value is not smaller.
// Revision : 1.0  initial release
// ============================================================================
module i8bit_div_step
    import i8bit_div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N:0]   prem_in,
    input  logic         dvd_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   prem_out,
    output logic         q_bit
);

    // Full-width shift so the compare sees every partial-remainder bit.
    logic [N+1:0] w_shift;
    logic         w_ge;

    assign w_shift = {prem_in, dvd_bit};
    assign w_ge    = (w_shift >= {2'b00, divisor});

    // Restore by not subtracting when the divisor does not fit.
    assign prem_out = w_ge ? (w_shift[N:0] - {1'b0, divisor}) : w_shift[N:0];
    assign q_bit    = w_ge;

endmodule
`default_nettype wire

// File: rtl/i8bit_div.sv
`default_nettype none
// ============================================================================
// Module   : i8bit_div
// Purpose  : Sequential restoring divider, 2N-bit dividend by N-bit divisor,
//            one quotient bit per clock. Results are registered and held
//            from the done pulse until the next accepted start.
// Options  : I8BIT_DIV_DBZ_EN - zero divisor is detected at start and the
//            iterations are skipped (done two edges after acceptance).
// Revision : 1.0  initial release
// ============================================================================
module i8bit_div
    import i8bit_div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz
);

    localparam int            CNT_W  = $clog2(2 * N);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * N - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0]   r_dvd;
    logic [N-1:0]     r_dvs;
    logic [N:0]       r_prem;
    logic [2*N-1:0]   r_quo;
    logic [2*N-1:0]   r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_dbz;
`ifdef I8BIT_DIV_DBZ_EN
    logic             r_skip;
`endif

    logic [N:0]       w_prem_next;
    logic             w_q_bit;
    logic [2*N-1:0]   w_quo_next;

    i8bit_div_step #(.N(N)) u_step (
        .prem_in  (r_prem),
        .dvd_bit  (r_dvd[2*N-1]),
        .divisor  (r_dvs),
        .prem_out (w_prem_next),
        .q_bit    (w_q_bit)
    );

    assign w_quo_next = {r_quo[2*N-2:0], w_q_bit};

    // Control FSM plus datapath; public results load only when finishing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef I8BIT_DIV_DBZ_EN
            r_skip      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_cnt   <= '0;
                        r_quo   <= '0;
                        r_state <= ST_RUN;
`ifdef I8BIT_DIV_DBZ_EN
                        r_skip  <= (divisor == '0);
`endif
                    end
                end
                ST_RUN: begin
`ifdef I8BIT_DIV_DBZ_EN
                    if (r_skip) begin
                        // Zero divisor short-cut: publish the fixed result.
                        r_quotient  <= '1;
                        r_remainder <= r_dvd[N-1:0];
                        r_dbz       <= 1'b1;
                        r_skip      <= 1'b0;
                        r_state     <= ST_DONE;
                    end else
`endif
                    begin
                        r_dvd  <= r_dvd << 1;
                        r_prem <= w_prem_next;
                        r_quo  <= w_quo_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_quotient  <= w_quo_next;
                            r_remainder <= w_prem_next[N-1:0];
                            r_dbz       <= (r_dvs == '0);
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;

endmodule
`default_nettype wire
